// File: rtl/nb_isa_pkg.sv
// Nibble CPU ISA constants, opcode length decode and fetch FSM state type.
// Shared by the fetch unit, its bus interface and the testbench.
package nb_isa_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_HALT = 4'h1;
  localparam opcode_t OP_LDI  = 4'h3;
  localparam opcode_t OP_OP4  = 4'h4;
  localparam opcode_t OP_OP5  = 4'h5;

  typedef enum logic [1:0] {
    FETCH0,
    FETCH1,
    PRESENT,
    HALT
  } fetch_state_e;

  // True for opcodes that carry an immediate byte after byte0.
  function automatic logic is_two_byte(input opcode_t op);
    return (op == OP_LDI) || (op == OP_OP4) || (op == OP_OP5);
  endfunction

endpackage

// File: rtl/nb_instr_fetch_if.sv
// Bus bundle between the fetch unit, the instruction memory and the execute stage.
// fetch modport: drives imem_addr and the decoded-instruction outputs;
//   receives imem_data, instr_ready and the jump redirect.
// env modport: the memory/execute side, the mirror image.
interface nb_instr_fetch_if;
  import nb_isa_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   opcode;
  logic [OP_W-1:0]   operand;
  logic [DATA_W-1:0] imm;
  logic              two_byte;
  logic [ADDR_W-1:0] instr_pc;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              halted;

  modport fetch (
    output imem_addr, instr_valid, opcode, operand, imm, two_byte, instr_pc, halted,
    input  imem_data, instr_ready, jump_en, jump_addr
  );

  modport env (
    input  imem_addr, instr_valid, opcode, operand, imm, two_byte, instr_pc, halted,
    output imem_data, instr_ready, jump_en, jump_addr
  );

endinterface

// File: rtl/nb_instr_fetch.sv
// Instruction fetch and pre-decode for the nibble CPU.
// Reads one or two bytes from a combinational instruction memory, presents the
// decoded instruction over valid/ready, and stops after HALT is accepted.
// Ports: clk, rst_n (synchronous, active-low), bus (fetch modport):
//   imem_addr/imem_data memory read, instr_* execute handshake,
//   jump_en/jump_addr redirect, halted status.
module nb_instr_fetch
  import nb_isa_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  nb_instr_fetch_if.fetch   bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  opcode_t           opcode_q, opcode_d;
  logic [OP_W-1:0]   operand_q, operand_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              two_byte_q, two_byte_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH0;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      opcode_q   <= '0;
      operand_q  <= '0;
      imm_q      <= '0;
      two_byte_q <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      imm_q      <= imm_d;
      two_byte_q <= two_byte_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state and next-output logic; a jump overrides every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    imm_d      = imm_q;
    two_byte_d = two_byte_q;
    valid_d    = valid_q;
    halted_d   = halted_q;

    if (bus.jump_en) begin
      // Drops any partial or unaccepted instruction.
      state_d  = FETCH0;
      pc_d     = bus.jump_addr;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH0: begin
          opcode_d   = bus.imem_data[DATA_W-1:OP_W];
          operand_d  = bus.imem_data[OP_W-1:0];
          instr_pc_d = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          imm_d      = '0;
          two_byte_d = is_two_byte(bus.imem_data[DATA_W-1:OP_W]);
          if (two_byte_d) begin
            state_d = FETCH1;
          end else begin
            state_d = PRESENT;
            valid_d = 1'b1;
          end
        end
        FETCH1: begin
          imm_d   = bus.imem_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = PRESENT;
          valid_d = 1'b1;
        end
        PRESENT: begin
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            if (opcode_q == OP_HALT) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              state_d = FETCH0;
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: state_d = FETCH0;
      endcase
    end
  end

  // imem_addr is the PC register itself, so the memory read has no input-to-output path.
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.imm         = imm_q;
  assign bus.two_byte    = two_byte_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.halted      = halted_q;

endmodule

// File: doc/nb_instr_fetch.md
# nb_instr_fetch

Instruction fetch and pre-decode unit for the nibble CPU. Acts as the reader of the 32-byte combinational instruction memory. It drives the memory address and assembles one- or two-byte instructions. It then hands each decoded instruction to the execute stage over a valid/ready handshake, and it honours jumps and the halt opcode.

## Interface
- ADDR_W, 5: instruction memory address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 8: instruction byte width; upper nibble is opcode, lower nibble is operand.
- RESET_PC, 0: PC value loaded by reset.

- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  ADDR_W  address to instruction memory; memory answers combinationally in the same cycle.
- imem_data  in  DATA_W  byte read at imem_addr.
- instr_valid  out  1  decoded instruction held on the outputs.
- instr_ready  in  1  execute stage accepts the instruction this cycle.
- opcode  out  4  byte0[7:4].
- operand  out  4  byte0[3:0].
- imm  out  8  byte1 for two-byte instructions, 0 otherwise.
- two_byte  out  1  instruction carried an immediate byte.
- instr_pc  out  ADDR_W  address of byte0.
- jump_en  in  1  redirect fetch.
- jump_addr  in  ADDR_W  redirect target.
- halted  out  1  halt opcode consumed; fetch stopped.

## Operation
- Opcode length rule:
  - opcodes 4'b0011, 4'b0100 and 4'b0101 are two-byte;
  - all others are one-byte;
  - 4'b0001 is HALT;
  - 4'b0000 (memory default fill) is a one-byte NOP passed through like any other opcode.
- States: FETCH0, FETCH1, PRESENT, HALT.
- FETCH0:
  - imem_addr=pc;
  - at the edge, latch byte0, set instr_pc<=pc and pc<=pc+1;
  - go to FETCH1 if two-byte, else PRESENT with imm=0.
- FETCH1:
  - imem_addr=pc;
  - at the edge, latch imm, pc<=pc+1, go to PRESENT.
- PRESENT:
  - instr_valid=1 and all outputs stable until accepted;
  - on instr_ready, go to HALT if opcode==HALT, else FETCH0.
- HALT:
  - halted=1, instr_valid=0, pc frozen, imem_addr=pc;
  - leaves only on jump_en or reset.
- jump_en has priority over everything in every state:
  - at the edge, pc<=jump_addr, instr_valid<=0, halted<=0, state<=FETCH0;
  - any partially fetched or un-accepted instruction is discarded;
  - jump_en together with instr_ready in PRESENT: the instruction counts as consumed (execute issued the jump) and no further effect follows.
- PC arithmetic is ADDR_W bits, unsigned; 31+1 wraps to 0, including a two-byte instruction at 31 whose imm is read from address 0.
- Reset (any cycle, mid-instruction included): pc=RESET_PC, state=FETCH0, instr_valid=0, halted=0, opcode/operand/imm/instr_pc=0, two_byte=0; imem_addr=RESET_PC.
- X/unused operand bits from memory are passed through unmodified; the block never decodes operand.

## Timing
- First instr_valid: 1 cycle after reset release for a one-byte instruction, 2 cycles for a two-byte instruction.
- Throughput with instr_ready tied high:
  - one-byte instruction every 2 cycles;
  - two-byte instruction every 3 cycles.
- After a jump_en edge, the target instruction is valid 1 or 2 cycles later, following the same rule.
- All outputs are registered except imem_addr, which is pc straight from the register. No combinational path from instr_ready or jump_en to any output.
- halted rises on the edge that accepts HALT; instr_valid falls on the same edge.

## Structure
- Package nb_isa_pkg holds:
  - ADDR_W/DATA_W defaults;
  - opcode constants OP_NOP, OP_HALT, OP_LDI (0011), OP_OP4 (0100), OP_OP5 (0101);
  - function is_two_byte(opcode);
  - the state enum type.
- No sub-module; a single FSM plus PC register.

## Test plan
- Reset then memory {0x35,0x00,0x20,0x10}, ready=1:
  - valid at cycle 2 with opcode=3, operand=5, imm=0x00, pc=0, two_byte=1;
  - cycle 4: opcode=2, operand=0, imm=0, pc=2;
  - cycle 6: HALT, accepted, then halted=1 with imem_addr stuck at 4.
- Backpressure: ready=0 for 5 cycles while PRESENT:
  - outputs stable and imem_addr frozen;
  - ready pulse gives exactly one acceptance, then fetch resumes at the next address.
- Wrap: jump to 31 with mem[31]=0x41 and mem[0]=0x04:
  - instruction opcode=4, operand=1, imm=0x04, instr_pc=31;
  - next fetch at address 1.
- jump_en in FETCH1 to address 8: the partial instruction is dropped, no valid is issued for it, and the next valid has instr_pc=8.
- jump_en while halted to 0: halted clears on that edge and the instruction at 0 becomes valid on schedule.
- rst_n low mid-FETCH1 for 1 cycle: all outputs return to reset values and the sequence restarts from address 0.
